decrypt_message: RTL
====================

DECRYPT_MESSAGE -- requirements
Module: decrypt_message

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, meaning the message length in bytes (1..32).
REQ-002 SHALL have port clk  input  1  meaning the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset_n  input  1  meaning reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  meaning begin one decrypt run, sampled only in IDLE.
REQ-005 SHALL have port finish  output  1  meaning a one-cycle pulse at the end of a run.
REQ-006 SHALL have port invalid  output  1  meaning a decrypted byte was not 'a'..'z' or space; valid only while finish=1.
REQ-007 SHALL have port s_addr  output  8  meaning the S-box RAM address.
REQ-008 SHALL have port s_wrdata  output  8  meaning the S-box RAM write data.
REQ-009 SHALL have port s_wren  output  1  meaning the S-box RAM write enable.
REQ-010 SHALL have port s_rddata  input  8  meaning the S-box RAM read data.
REQ-011 SHALL have port enc_addr  output  5  meaning the encrypted-message ROM address.
REQ-012 SHALL have port enc_rddata  input  8  meaning the ROM read data.
REQ-013 SHALL have port dec_addr  output  5  meaning the decrypted RAM address.
REQ-014 SHALL have port dec_wrdata  output  8  meaning the decrypted RAM write data.
REQ-015 SHALL have port dec_wren  output  1  meaning the decrypted RAM write enable.

Function
REQ-016 SHALL implement the RC4 PRGA on the S-box left by the key-schedule stage: i=j=0; for k=0..MSG_LEN-1: i=i+1; j=j+s[i]; swap s[i],s[j]; f=s[s[i]+s[j]]; dec[k]=f XOR enc[k].
REQ-017 SHALL compute i, j and the f address as 8-bit sums that wrap modulo 256; k is 5 bits.
REQ-018 SHALL treat every RAM and ROM as synchronous read, with data valid one cycle after the address is presented; each read therefore takes an ADDR state and a LATCH state.
REQ-019 SHALL use the states IDLE, INC_I, RD_SI_A, RD_SI_L, ADD_J, RD_SJ_A, RD_SJ_L, WR_SI, WR_SJ, RD_F_A, RD_F_L, WR_DEC, INC_K and DONE; each state lasts one cycle and they follow in that order, except where REQ-020 and REQ-021 say otherwise.
REQ-020 SHALL branch at the end of each byte:
- From WR_DEC: go to DONE if the byte is invalid, otherwise to INC_K.
- From INC_K: go to DONE if k==MSG_LEN-1, otherwise increment k and go to INC_I.
REQ-021 SHALL go from IDLE to INC_I when start=1, and from DONE to IDLE.
REQ-022 SHALL take 12 cycles per byte; finish SHALL be high exactly 12*MSG_LEN+1 cycles after the edge that samples start, or at cycle 12*(k+1) on an early abort at byte k.
REQ-023 SHALL drive s_wren=1 only in WR_SI (addr i, data latched s[j]) and WR_SJ (addr j, data latched s[i]); when i==j both writes occur and the value is unchanged.
REQ-024 SHALL form the f address from the latched pre-swap s[i]+s[j]; this equals the post-swap sum.
REQ-025 SHALL use the S-box as modified by the swap when the f address equals i or j.
REQ-026 SHALL hold enc_addr=k and dec_addr=k throughout each byte.
REQ-027 SHALL drive dec_wren=1 only in WR_DEC, with dec_wrdata = f XOR enc_rddata.
REQ-028 SHALL set invalid when the written byte is outside {0x20, 0x61..0x7A}, and SHALL clear invalid on each start.
REQ-029 SHALL ignore start outside IDLE; start held high SHALL begin a new run in the cycle after DONE.
REQ-030 SHALL leave s_addr and s_wrdata don't-care when s_wren=0.

Reset
REQ-031 SHALL, on any edge with reset_n=0 (including mid-run), enter IDLE and set i, j, k, finish, invalid, s_wren, dec_wren, s_addr, enc_addr and dec_addr to 0.
REQ-032 SHALL NOT restore S-box contents after reset; the upstream key schedule must re-run.

Structure
REQ-033 SHALL place the state enum, MSG_LEN default and valid-character constants (0x20, 0x61, 0x7A) in shared package rc4_pkg.
REQ-034 SHALL implement the character test in the combinational sub-module rc4_char_check (8-bit in, 1-bit valid out).

Verification
REQ-035 Reset: reset_n=0 for 3 cycles with start=1 -> finish=0, s_wren=0, dec_wren=0, no RAM activity.
REQ-036 Keystream and i==j swap: s[n]=n, enc[0..2]=0x63,0x67,0x66 ->
- keystream 0x02,0x05,0x07;
- dec[0..2]='a','b','a';
- s[1] stays 0x01; s[2]=0x03, s[3]=0x05, s[5]=0x02.
REQ-037 Full run: golden-model S and enc, MSG_LEN=32, all valid -> finish at cycle 385, invalid=0, dec matches the model, 64 s_wren pulses.
REQ-038 Early abort: s[n]=n, enc all 0x00 -> dec[0]=0x02 written, finish at cycle 12, invalid=1, one dec_wren pulse.
REQ-039 Reset mid-run: reset_n=0 at cycle 50 -> IDLE next edge; the restarted run completes with the correct timing.
REQ-040 start held high -> busy-time start ignored; a second run begins the cycle after DONE with invalid cleared.

Source files
------------

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc4_pkg
// Purpose  : Shared RC4 PRGA state encoding, message length and charset bounds
// Revision : 1.0
// ============================================================================
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] c_CHAR_SPACE = 8'h20;
  localparam logic [7:0] c_CHAR_LO    = 8'h61;
  localparam logic [7:0] c_CHAR_HI    = 8'h7A;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INC_I  = 4'd1,
    ST_RD_SI_A = 4'd2,
    ST_RD_SI_L = 4'd3,
    ST_ADD_J  = 4'd4,
    ST_RD_SJ_A = 4'd5,
    ST_RD_SJ_L = 4'd6,
    ST_WR_SI  = 4'd7,
    ST_WR_SJ  = 4'd8,
    ST_RD_F_A = 4'd9,
    ST_RD_F_L = 4'd10,
    ST_WR_DEC = 4'd11,
    ST_INC_K  = 4'd12,
    ST_DONE   = 4'd13
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_char_check.sv
`default_nettype none
// ============================================================================
// Module   : rc4_char_check
// Purpose  : Flags a byte as plaintext-legal (lower-case letter or space)
// Revision : 1.0
// ============================================================================
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid
);

  assign o_valid = (i_char == c_CHAR_SPACE) ||
                   ((i_char >= c_CHAR_LO) && (i_char <= c_CHAR_HI));

endmodule
`default_nettype wire

// File: rtl/decrypt_message.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_message
// Purpose  : RC4 PRGA over an externally keyed S-box, one byte per 12 cycles
// Revision : 1.0
// ============================================================================
module decrypt_message
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       finish,
  output logic       invalid,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  input  logic [7:0] s_rddata,
  output logic [4:0] enc_addr,
  input  logic [7:0] enc_rddata,
  output logic [4:0] dec_addr,
  output logic [7:0] dec_wrdata,
  output logic       dec_wren
);

  localparam logic [4:0] c_LAST_K = 5'(MSG_LEN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_i, r_j, r_si, r_sj, r_f;
  logic [4:0] r_k;
  logic       r_invalid;
  logic [7:0] w_f_addr;
  logic [7:0] w_dec_byte;
  logic       w_char_ok;

  // Pre-swap sum equals post-swap sum, so the latched values address f directly
  assign w_f_addr   = r_si + r_sj;
  assign w_dec_byte = r_f ^ enc_rddata;

  rc4_char_check u_char_check (
    .i_char  (w_dec_byte),
    .o_valid (w_char_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_INC_I;
      ST_INC_I:   w_state_nxt = ST_RD_SI_A;
      ST_RD_SI_A: w_state_nxt = ST_RD_SI_L;
      ST_RD_SI_L: w_state_nxt = ST_ADD_J;
      ST_ADD_J:   w_state_nxt = ST_RD_SJ_A;
      ST_RD_SJ_A: w_state_nxt = ST_RD_SJ_L;
      ST_RD_SJ_L: w_state_nxt = ST_WR_SI;
      ST_WR_SI:   w_state_nxt = ST_WR_SJ;
      ST_WR_SJ:   w_state_nxt = ST_RD_F_A;
      ST_RD_F_A:  w_state_nxt = ST_RD_F_L;
      ST_RD_F_L:  w_state_nxt = ST_WR_DEC;
      ST_WR_DEC:  w_state_nxt = w_char_ok ? ST_INC_K : ST_DONE;
      ST_INC_K:   w_state_nxt = (r_k == c_LAST_K) ? ST_DONE : ST_INC_I;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    dec_wren = 1'b0;
    unique case (r_state)
      ST_RD_SI_A: s_addr = r_i;
      ST_RD_SJ_A: s_addr = r_j;
      ST_WR_SI: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
      end
      ST_RD_F_A:  s_addr = w_f_addr;
      ST_WR_DEC:  dec_wren = 1'b1;
      default:    s_addr = 8'h00;
    endcase
  end

  assign finish     = (r_state == ST_DONE);
  assign invalid    = r_invalid;
  assign enc_addr   = r_k;
  assign dec_addr   = r_k;
  assign dec_wrdata = w_dec_byte;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_i       <= 8'h00;
      r_j       <= 8'h00;
      r_k       <= 5'd0;
      r_si      <= 8'h00;
      r_sj      <= 8'h00;
      r_f       <= 8'h00;
      r_invalid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_i       <= 8'h00;
          r_j       <= 8'h00;
          r_k       <= 5'd0;
          r_invalid <= 1'b0;
        end
        ST_INC_I:   r_i  <= r_i + 8'd1;
        ST_RD_SI_L: r_si <= s_rddata;
        ST_ADD_J:   r_j  <= r_j + r_si;
        ST_RD_SJ_L: r_sj <= s_rddata;
        ST_RD_F_L:  r_f  <= s_rddata;
        ST_WR_DEC:  r_invalid <= ~w_char_ok;
        ST_INC_K:   if (r_k != c_LAST_K) r_k <= r_k + 5'd1;
        default:    r_f  <= r_f;
      endcase
    end
  end

endmodule
`default_nettype wire
